// File: rtl/pop_sequence_monitor_pkg.sv
// pop_sequence_monitor_pkg: shared state encodings, error codes and default widths for the POP monitor.
package pop_sequence_monitor_pkg;
    localparam int CNT_WIDTH_DEF = 20;
    localparam int SEQ_CNT_WIDTH_DEF = 16;
    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_PUMP,
        ST_DARK1,
        ST_MW,
        ST_DARK2,
        ST_PROBE,
        ST_REPORT
    } state_t;
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ORDER   = 3'd1,
        ERR_OVERLAP = 3'd2,
        ERR_SAMPLE  = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_t;
endpackage

// File: rtl/pop_sequence_monitor_input_sync.sv
// pop_input_sync: registers negedge-launched pin levels and derives a rise strobe per input.
module pop_input_sync #(
    parameter int N = 4
) (
    input  logic         clock_2_5M,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic [N-1:0] rise
);
    logic [N-1:0] q_d;
    always_ff @(posedge clock_2_5M) begin
        if (reset) begin
            q   <= '0;
            q_d <= '0;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end
    assign rise = q & ~q_d;
endmodule

// File: rtl/pop_sequence_monitor.sv
// pop_sequence_monitor: decodes pump/MW/probe/sample pin activity into per-cycle interval widths and fault codes.
module pop_sequence_monitor
    import pop_sequence_monitor_pkg::*;
#(
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter int SEQ_CNT_WIDTH = SEQ_CNT_WIDTH_DEF
) (
    input  logic                     clock_2_5M,
    input  logic                     reset,
    input  logic                     pump,
    input  logic                     probe,
    input  logic                     MW,
    input  logic                     sample,
    output logic [CNT_WIDTH-1:0]     pump_width,
    output logic [CNT_WIDTH-1:0]     dark1_width,
    output logic [CNT_WIDTH-1:0]     mw_width,
    output logic [CNT_WIDTH-1:0]     dark2_width,
    output logic [CNT_WIDTH-1:0]     probe_width,
    output logic                     result_valid,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [SEQ_CNT_WIDTH-1:0] seq_count,
    output logic                     busy
);
    logic [3:0] lv, rs;
    logic pump_q, probe_q, mw_q, sample_q, mw_r, probe_r, unused_rise;
    logic ov, od, sm, counting, sat;
    logic [CNT_WIDTH-1:0] cnt, pw_l, d1_l, mw_l, d2_l;
    state_t state, next;
    err_t err;

    pop_input_sync #(.N(4)) u_sync (
        .clock_2_5M(clock_2_5M),
        .reset(reset),
        .d({sample, MW, probe, pump}),
        .q(lv),
        .rise(rs)
    );

    assign {sample_q, mw_q, probe_q, pump_q} = lv;
    assign mw_r = rs[2];
    assign probe_r = rs[1];
    assign unused_rise = rs[3] ^ rs[0];
    assign counting = state inside {ST_PUMP, ST_DARK1, ST_MW, ST_DARK2, ST_PROBE};
    assign sat = &cnt;
    assign result_valid = state == ST_REPORT;

    always_comb begin
        next = state;
        ov = 1'b0;
        od = 1'b0;
        sm = 1'b0;
        case (state)
            ST_RESYNC: next = (pump_q | probe_q | mw_q) ? ST_RESYNC : ST_IDLE;
            ST_IDLE: begin
                od = mw_q | probe_q;
                next = pump_q ? ST_PUMP : ST_IDLE;
            end
            ST_PUMP: begin
                ov = (pump_q & (mw_q | probe_q)) | (mw_q & probe_q);
                od = ~pump_q & ~mw_q & probe_q;
                next = pump_q ? ST_PUMP : mw_q ? ST_MW : ST_DARK1;
            end
            ST_DARK1: begin
                ov = pump_q | (mw_q & probe_q);
                od = probe_q & ~mw_q;
                next = mw_r ? ST_MW : ST_DARK1;
            end
            ST_MW: begin
                ov = pump_q | (mw_q & probe_q);
                next = mw_q ? ST_MW : probe_q ? ST_PROBE : ST_DARK2;
            end
            ST_DARK2: begin
                ov = pump_q;
                od = mw_q;
                next = probe_r ? ST_PROBE : ST_DARK2;
            end
            ST_PROBE: begin
                ov = pump_q | mw_q;
                sm = ~sample_q;
                next = probe_q ? ST_PROBE : ST_REPORT;
            end
            default: next = ST_IDLE;
        endcase
        err = ov ? ERR_OVERLAP : od ? ERR_ORDER : sm ? ERR_SAMPLE :
              (counting && sat) ? ERR_TIMEOUT : ERR_NONE;
        if (err != ERR_NONE) next = ST_RESYNC;
    end

    // the transition cycle itself is the first counted cycle of the new interval
    always_ff @(posedge clock_2_5M) begin
        if (reset) begin
            state       <= ST_RESYNC;
            cnt         <= '0;
            pw_l        <= '0;
            d1_l        <= '0;
            mw_l        <= '0;
            d2_l        <= '0;
            pump_width  <= '0;
            dark1_width <= '0;
            mw_width    <= '0;
            dark2_width <= '0;
            probe_width <= '0;
            seq_count   <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            busy        <= 1'b0;
        end else begin
            state <= next;
            cnt <= (next != state) ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(counting & ~sat);
            if (state == ST_PUMP && next != ST_PUMP) pw_l <= cnt;
            if (next == ST_MW && state != ST_MW) d1_l <= (state == ST_DARK1) ? cnt : '0;
            if (state == ST_MW && next != ST_MW) mw_l <= cnt;
            if (next == ST_PROBE && state != ST_PROBE) d2_l <= (state == ST_DARK2) ? cnt : '0;
            if (state == ST_PROBE && next == ST_REPORT) begin
                pump_width  <= pw_l;
                dark1_width <= d1_l;
                mw_width    <= mw_l;
                dark2_width <= d2_l;
                probe_width <= cnt;
                seq_count   <= seq_count + SEQ_CNT_WIDTH'(1);
            end
            err_valid <= err != ERR_NONE;
            if (err != ERR_NONE) err_code <= err;
            busy <= next != ST_IDLE;
        end
    end
endmodule

// File: doc/pop_sequence_monitor.md
Name: pop_sequence_monitor

Overview:
- Receiving end of the POP timing outputs: samples pump, probe, MW and sample as driven to the pins and decodes each POP cycle back into measured intervals.
- Reports pump width, dark gap 1, MW width, dark gap 2 and probe width in clock_2_5M cycles, and flags ordering, overlap, sample-gating and timeout faults.
- Sits beside the output register stage and feeds the debug/readback logic and the self-check bench.

Parameters:
- CNT_WIDTH, 20, width of every interval counter and result; 2^20 cycles at 2.5 MHz is about 420 ms.
- SEQ_CNT_WIDTH, 16, width of the good-sequence counter.

Ports:
- clock_2_5M  input  1  system clock, 2.5 MHz.
- reset  input  1  synchronous reset, active-high.
- pump  input  1  pump drive as presented to the output pin.
- probe  input  1  probe drive.
- MW  input  1  microwave drive.
- sample  input  1  sample/acquire gate.
- pump_width  output  CNT_WIDTH  cycles pump was high.
- dark1_width  output  CNT_WIDTH  cycles from pump fall to MW rise.
- mw_width  output  CNT_WIDTH  cycles MW was high.
- dark2_width  output  CNT_WIDTH  cycles from MW fall to probe rise.
- probe_width  output  CNT_WIDTH  cycles probe was high.
- result_valid  output  1  one-cycle strobe; all width outputs updated together.
- err_valid  output  1  one-cycle error strobe.
- err_code  output  3  error code, held until the next err_valid.
- seq_count  output  SEQ_CNT_WIDTH  number of good sequences, wraps to 0.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Single clock and synchronous active-high reset. The clock is clock_2_5M and the reset is reset, both in the interface above.
- Reset: all width outputs 0, result_valid 0, err_valid 0, err_code 0, seq_count 0, busy 0, state RESYNC. Reset mid-sequence discards any partial measurement.
- Inputs are registered once on posedge clock_2_5M, because the sources change on negedge. All decoding uses the registered copies, giving 1 cycle of input latency.
- A single counter is cleared on each state entry and incremented each cycle in a counting state. It saturates at all-ones.
- States and transitions:
  - RESYNC: wait until pump, probe and MW are all low, then go to IDLE.
  - IDLE: pump rise goes to PUMP with counter=1. MW or probe rise raises ORDER and goes to RESYNC.
  - PUMP: count while pump is high. On pump low, latch pump_width and go to DARK1.
  - DARK1: count until MW rises. On MW rise, latch dark1_width and go to MW.
  - MW: count while MW is high. On MW low, latch mw_width and go to DARK2.
  - DARK2: count until probe rises. On probe rise, latch dark2_width and go to PROBE.
  - PROBE: count while probe is high. On probe low, latch probe_width and go to REPORT.
  - REPORT: one cycle. Pulse result_valid, increment seq_count, go to IDLE.
- Width latching is internal. The visible outputs update only at REPORT, so consumers never see a mixed set.
- result_valid is asserted 2 cycles after the raw probe input falls.
- Error codes:
  - 1 ORDER: pulse rises out of sequence.
  - 2 OVERLAP: a second drive is high in a counting state. Applies to pump, MW and probe, including pump re-rising during DARK1/DARK2.
  - 3 SAMPLE: registered sample is low during any PROBE cycle.
  - 4 TIMEOUT: the counter saturates in any counting state.
- Any error: pulse err_valid with err_code for one cycle and go to RESYNC. Outputs keep their previous good values and seq_count does not change.
- Priority when events coincide in one cycle: OVERLAP > ORDER > SAMPLE > TIMEOUT > normal transition.
- A normal end of interval and a same-cycle rise of the next pulse (for example, pump low and MW high together) is legal: dark1_width=0, then go directly to MW.
- sample is ignored outside PROBE. In state 0 and the dark state, sample is permanently high and that is legal.
- A permanently high pump (pump calibration state) produces a TIMEOUT after 2^CNT_WIDTH-1 cycles and then stays in RESYNC. This is the intended behaviour.

Decomposition:
- Shared header pop_defs.vh holds the state encodings, the err_code values (ORDER=1, OVERLAP=2, SAMPLE=3, TIMEOUT=4) and the default CNT_WIDTH.
- One sub-module, pop_input_sync: registers the 4 inputs and produces the registered level plus a rise strobe per input. It is reused by other pin monitors.

Test Plan:
- Nominal: pump high 10, gap 5, MW 20, gap 3, probe 8 with sample high throughout -> widths 10/5/20/3/8, result_valid for exactly 1 cycle 2 cycles after probe falls, seq_count=1, err_valid never.
- Back-to-back: pump falls and MW rises on the same edge, other values as nominal -> dark1_width=0, no error. Two consecutive sequences -> seq_count=2.
- Order fault: probe pulses from IDLE -> err_valid with err_code=1. Next clean sequence measures correctly.
- Overlap and sample faults: MW goes high during PUMP -> err_code=2. Sample drops for 1 cycle mid-probe -> err_code=3, widths unchanged from the prior good result.
- Timeout: pump held high with CNT_WIDTH=8 -> err_code=4 after 255 counted cycles, busy stays high until pump goes low, then returns to IDLE.
- Reset mid-PROBE: assert reset for 1 cycle -> all outputs 0, state RESYNC. The still-high probe is not measured, and the next full sequence reports correct widths.
